// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state type and LED helpers for led_decode_scan
package led_pkg;

  typedef enum logic [1:0] {BLANK, DECODE, SCAN} led_state_t;

  localparam int LED_MAX_W = 64;
  localparam int LED_IDX_W = 6;
  localparam logic [LED_MAX_W-1:0] LED_ALL_OFF = '1;

  // Active-low one-hot; an index at or beyond width leaves every LED dark.
  function automatic logic [LED_MAX_W-1:0] onehot_n(input logic [LED_IDX_W-1:0] index,
                                                    input int width);
    logic [LED_MAX_W-1:0] v;
    v = LED_ALL_OFF;
    if (int'(index) < width) v[index] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser plus stable-count debounce for switch inputs
module sw_debounce #(
  parameter int W          = 3,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [W-1:0]     r_sync1;
  logic [W-1:0]     r_sync2;
  logic [W-1:0]     r_cand;
  logic [W-1:0]     r_accepted;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cand     <= '0;
      r_accepted <= '0;
      r_cnt      <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      // Any disagreement restarts the stability count from zero.
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_accepted <= r_cand;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dout = r_accepted;

endmodule

// File: rtl/led_decode_scan.sv
// rtl/led_decode_scan.sv - debounced switch decoder with scan mode driving an active-low LED bar
module led_decode_scan
  import led_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int OUT_W      = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sw,
  output logic [OUT_W-1:0] led,
  output logic [SEL_W-1:0] idx
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0]  POS_LAST  = SEL_W'(OUT_W - 1);

  logic [SEL_W-1:0]  w_accepted;
  logic [SEL_W-1:0]  w_pos_next;
  led_state_t        r_state;
  logic [TICK_W-1:0] r_tick;
  logic [SEL_W-1:0]  r_pos;

  sw_debounce #(
    .W          (SEL_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sw),
    .dout  (w_accepted)
  );

  assign w_pos_next = (r_pos == POS_LAST) ? '0 : r_pos + SEL_W'(1);

  // Outputs are computed from the state being entered, so every change shows on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_tick  <= '0;
      r_pos   <= '0;
      led     <= '1;
      idx     <= '0;
    end else if (!en) begin
      r_state <= BLANK;
      led     <= OUT_W'(LED_ALL_OFF);
    end else if (!mode) begin
      r_state <= DECODE;
      led     <= OUT_W'(onehot_n(LED_IDX_W'(w_accepted), OUT_W));
      idx     <= w_accepted;
    end else if (r_state != SCAN) begin
      r_state <= SCAN;
      r_tick  <= '0;
      r_pos   <= '0;
      led     <= OUT_W'(onehot_n('0, OUT_W));
      idx     <= '0;
    end else if (r_tick == TICK_LAST) begin
      r_tick <= '0;
      r_pos  <= w_pos_next;
      led    <= OUT_W'(onehot_n(LED_IDX_W'(w_pos_next), OUT_W));
      idx    <= w_pos_next;
    end else begin
      r_tick <= r_tick + TICK_W'(1);
    end
  end

endmodule

// File: tb/tb_led_decode_scan.sv
// tb/tb_led_decode_scan.sv - randomized self-checking bench for led_decode_scan (OUT_W=8 and OUT_W=5)
module tb_led_decode_scan;

  localparam int SEL_W = 3;
  localparam int DEB   = 4;
  localparam int TICK  = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             en    = 1'b0;
  logic             mode  = 1'b0;
  logic [SEL_W-1:0] sw    = '0;
  logic [7:0]       led8;
  logic [2:0]       idx8;
  logic [4:0]       led5;
  logic [2:0]       idx5;

  always #5 clk = ~clk;

  led_decode_scan #(.SEL_W(SEL_W), .OUT_W(8), .DEB_CYCLES(DEB), .TICK_DIV(TICK)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sw(sw), .led(led8), .idx(idx8)
  );

  led_decode_scan #(.SEL_W(SEL_W), .OUT_W(5), .DEB_CYCLES(DEB), .TICK_DIV(TICK)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sw(sw), .led(led5), .idx(idx5)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted value = sw seen two edges ago once it has been steady
  // for DEB+1 consecutive samples; scan position derived from cycles spent in scan.
  int hist[$];
  int m_acc;
  int m_state;
  int m_scan_cycles;
  int m_idx[2];
  int m_led[2];
  int owidth[2] = '{8, 5};

  function automatic int led_of(input int k, input int w);
    int all;
    all = (1 << w) - 1;
    if (k >= w) return all;
    return all & ~(1 << k);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 3; i++) hist.push_back(0);
    m_acc         = 0;
    m_state       = 0;
    m_scan_cycles = 0;
    for (int d = 0; d < 2; d++) begin
      m_idx[d] = 0;
      m_led[d] = (1 << owidth[d]) - 1;
    end
  endtask

  task automatic model_edge();
    int acc_before;
    bit stable;
    acc_before = m_acc;
    hist.push_back(int'(sw));
    void'(hist.pop_front());
    stable = 1'b1;
    for (int i = 1; i <= DEB; i++) if (hist[i] != hist[0]) stable = 1'b0;
    if (stable) m_acc = hist[DEB];
    if (!en) begin
      m_state = 0;
      for (int d = 0; d < 2; d++) m_led[d] = (1 << owidth[d]) - 1;
    end else if (!mode) begin
      m_state = 1;
      for (int d = 0; d < 2; d++) begin
        m_led[d] = led_of(acc_before, owidth[d]);
        m_idx[d] = acc_before;
      end
    end else begin
      if (m_state != 2) m_scan_cycles = 0;
      else m_scan_cycles++;
      m_state = 2;
      for (int d = 0; d < 2; d++) begin
        m_idx[d] = (m_scan_cycles / TICK) % owidth[d];
        m_led[d] = led_of(m_idx[d], owidth[d]);
      end
    end
  endtask

  task automatic check_all();
    check_eq("led8", 32'(led8), m_led[0]);
    check_eq("idx8", 32'(idx8), m_idx[0]);
    check_eq("led5", 32'(led5), m_led[1]);
    check_eq("idx5", 32'(idx5), m_idx[1]);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic async_reset_pulse();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    step();
    step();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 1'b0;
    sw    = '0;
    repeat (3) step();
    #2;
    rst_n = 1'b1;
    run(10);

    for (int k = 0; k < 8; k++) begin
      sw = SEL_W'(k);
      run(20);
    end

    sw = 3'd2; run(2);
    sw = 3'd5; run(2);
    sw = 3'd2; run(2);
    sw = 3'd5; run(20);

    mode = 1'b1; run(TICK * 9 + 4);
    mode = 1'b0; run(6);
    mode = 1'b1; run(20);

    mode = 1'b0; sw = 3'd6; run(12);
    mode = 1'b1; run(TICK * 6);

    mode = 1'b0; run(10);
    en = 1'b0; mode = 1'b1; run(3);
    en = 1'b1; run(10);

    async_reset_pulse();
    en = 1'b1; mode = 1'b1;
    run(TICK * 3);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) sw = SEL_W'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_decode_scan.md
Name: led_decode_scan

Overview:
Parametrised active-low one-hot LED driver fed from board switches. It generalises the 3-to-8 switch decoder in three ways: switch width is a parameter, switches are synchronised and debounced, and outputs are registered. It adds a scan mode that walks a single lit LED across the bar. It sits between the raw switch pins and the LED pins of the lab board top level.

Parameters:
SEL_W, 3, width of the switch select input; valid range 1..6.
OUT_W, 8, number of LEDs; valid range 1..2**SEL_W.
DEB_CYCLES, 500000, consecutive stable clocks required to accept a switch value; minimum 1.
TICK_DIV, 25000000, clocks per scan step in scan mode; minimum 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  synchronous enable; 0 blanks all LEDs.
mode  input  1  synchronous; 0 = decode, 1 = scan.
sw  input  SEL_W  raw asynchronous switch inputs.
led  output  OUT_W  LED drive, active-low (0 = lit), registered.
idx  output  SEL_W  index currently lit, registered; meaningful only when exactly one LED is lit.

Behaviour:
- Reset (rst_n low, asynchronous):
  - led = all ones; idx = 0.
  - Sync flops, candidate, accepted value, debounce count, tick count and scan position all clear to 0.
  - State = BLANK.
- Synchroniser: two-flop chain on sw. en and mode are already synchronous and are used directly.
- Debounce, per clock, using the synchronised sample s:
  - If s != candidate: candidate <= s; cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: accepted <= candidate; cnt holds.
  - Else: cnt <= cnt+1.
  - A bounce resets the count.
- Debounce latency: with sw held stable after a change, led reflects the new value on the (DEB_CYCLES+4)th rising edge after the change.
- State machine:
  - BLANK: entered when en=0, from any state, on the next edge.
  - DECODE: entered when en=1 and mode=0.
  - SCAN: entered when en=1 and mode=1.
  - Every transition takes effect on the next edge.
- BLANK: led = all ones; idx holds its last value.
- DECODE: led = ~(1 << accepted); idx = accepted.
  - If accepted >= OUT_W, led = all ones and idx = accepted; no LED is lit and nothing wraps.
- SCAN tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - Each wrap (tick) advances the scan position: pos = pos+1, and pos = OUT_W-1 wraps to 0.
  - led = ~(1 << pos); idx = pos.
- Entering SCAN from any other state: pos <= 0 and tick counter <= 0 on the entry edge, so LED0 lights immediately.
- SCAN -> SCAN (mode held): position and counter are preserved.
- Leaving SCAN: the counter freezes; pos is discarded and restarts at 0 on the next entry.
- Debounce keeps running in all states, so returning to DECODE shows the current accepted value with no extra latency.
- Simultaneous en fall and mode change: en has priority, so the next state is BLANK.
- Reset mid-scan or mid-debounce: everything returns to reset values immediately. A partially counted debounce is lost.
- Widths:
  - Debounce counter is $clog2(DEB_CYCLES+1) bits, saturating at DEB_CYCLES-1.
  - Tick counter is $clog2(TICK_DIV) bits.
  - pos is SEL_W bits.
- No combinational path from any input to led or idx.

Decomposition:
- Shared package led_pkg:
  - State enum {BLANK, DECODE, SCAN}.
  - Function onehot_n(index, width): active-low one-hot with an out-of-range -> all-ones rule.
  - Constant LED_ALL_OFF.
- One sub-module, sw_debounce: parameters W and DEB_CYCLES; ports clk, rst_n, din[W], dout[W]. It contains the synchroniser and the debounce counter. The top level instantiates it once with W=SEL_W.

Test Plan:
All scenarios use SEL_W=3, OUT_W=8, DEB_CYCLES=4, TICK_DIV=8 unless stated.
1. Reset, then en=1, mode=0, sw=3'b000 held -> led=8'b1111_1110 (bit 0 low) and idx=0 by edge 8 after rst_n release; led=all ones during reset.
2. Decode sweep: sw 0..7, each held 20 clocks -> led bit k low only and idx=k; every change lands exactly DEB_CYCLES+4=8 edges after the sw change.
3. Bounce: sw toggles 2->5->2->5 every 2 clocks, then holds 5 -> led never shows an intermediate value; led=~8'b0010_0000 exactly 8 edges after the final toggle.
4. Scan: mode=1 -> idx sequence 0,1,...,7,0 advancing every 8 clocks; wrap from 7 to 0 is checked. mode=0 mid-scan -> immediately shows the debounced sw. mode=1 again -> restarts at idx 0.
5. OUT_W=5, sw=3'd6 in DECODE -> led=5'b11111, idx=6. In SCAN -> wraps 4->0.
6. en=0 and mode 0->1 on the same edge -> BLANK, led all ones. rst_n pulsed low mid-scan (asynchronous, not clock-aligned) -> led all ones within the same cycle; after release and en=1, mode=1 -> scan restarts at idx 0.
